// File: rtl/tg_pulse_seq_if.sv
// Bundle of the tg_pulse_seq request, configuration and pulse-output signals.
// The master drives requests and configuration; the slave is the sequencer.
interface tg_pulse_seq_if #(
   parameter int CNT_W = 4
);
   logic             tg_start;
   logic             tg_abort;
   logic [CNT_W-1:0] B_test1;
   logic [CNT_W-1:0] B_test2;
   logic [CNT_W-1:0] B_test3;
   logic             DA_test1;
   logic             DA_test2;
   logic             DA_test3;
   logic [CNT_W-1:0] DA_test4;
   logic             tg_busy;

   modport master (
      output tg_start, tg_abort, B_test1, B_test2, B_test3,
      input  DA_test1, DA_test2, DA_test3, DA_test4, tg_busy
   );

   modport slave (
      input  tg_start, tg_abort, B_test1, B_test2, B_test3,
      output DA_test1, DA_test2, DA_test3, DA_test4, tg_busy
   );
endinterface

// File: rtl/tg_pulse_seq.sv
// Two-pulse sequencer: width1 / gap / width2 from a latched config, then a
// one-cycle done strobe and a wrapping completed-burst count.
module tg_pulse_seq #(
   parameter int CNT_W = 4
) (
   input  logic         clk,
   input  logic         C_purstb,
   tg_pulse_seq_if.slave bus
);

   localparam logic [2:0] IDLE = 3'd0;
   localparam logic [2:0] P1   = 3'd1;
   localparam logic [2:0] GAP  = 3'd2;
   localparam logic [2:0] P2   = 3'd3;
   localparam logic [2:0] DONE = 3'd4;

   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] ZERO = '0;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] w1_q, w1_d;
   logic [CNT_W-1:0] g_q, g_d;
   logic [CNT_W-1:0] w2_q, w2_d;
   logic             da1_q, da1_d;
   logic             da2_q, da2_d;
   logic             da3_q, da3_d;
   logic [CNT_W-1:0] da4_q, da4_d;
   logic             busy_q, busy_d;

   // Each segment runs for cnt+1 cycles; a zero-length segment is skipped by
   // jumping straight to the next non-zero one.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      w1_d    = w1_q;
      g_d     = g_q;
      w2_d    = w2_q;

      if (bus.tg_abort) begin
         state_d = IDLE;
         cnt_d   = ZERO;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.tg_start) begin
                  w1_d = bus.B_test1;
                  g_d  = bus.B_test2;
                  w2_d = bus.B_test3;
                  if (bus.B_test1 != ZERO) begin
                     state_d = P1;
                     cnt_d   = bus.B_test1 - ONE;
                  end else if (bus.B_test2 != ZERO) begin
                     state_d = GAP;
                     cnt_d   = bus.B_test2 - ONE;
                  end else if (bus.B_test3 != ZERO) begin
                     state_d = P2;
                     cnt_d   = bus.B_test3 - ONE;
                  end else begin
                     state_d = DONE;
                     cnt_d   = ZERO;
                  end
               end
            end
            P1: begin
               if (cnt_q != ZERO) begin
                  cnt_d = cnt_q - ONE;
               end else if (g_q != ZERO) begin
                  state_d = GAP;
                  cnt_d   = g_q - ONE;
               end else if (w2_q != ZERO) begin
                  state_d = P2;
                  cnt_d   = w2_q - ONE;
               end else begin
                  state_d = DONE;
               end
            end
            GAP: begin
               if (cnt_q != ZERO) begin
                  cnt_d = cnt_q - ONE;
               end else if (w2_q != ZERO) begin
                  state_d = P2;
                  cnt_d   = w2_q - ONE;
               end else begin
                  state_d = DONE;
               end
            end
            P2: begin
               if (cnt_q != ZERO) begin
                  cnt_d = cnt_q - ONE;
               end else begin
                  state_d = DONE;
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Outputs are a registered decode of the current state, so they trail the
   // state by one edge; abort suppresses them on the very edge it is sampled.
   always_comb begin
      da1_d  = !bus.tg_abort && (state_q == P1);
      da2_d  = !bus.tg_abort && (state_q == P2);
      da3_d  = !bus.tg_abort && (state_q == DONE);
      busy_d = !bus.tg_abort && (state_q != IDLE);
      da4_d  = da3_d ? (da4_q + ONE) : da4_q;
   end

   always_ff @(posedge clk or negedge C_purstb) begin
      if (!C_purstb) begin
         state_q <= IDLE;
         cnt_q   <= ZERO;
         w1_q    <= ZERO;
         g_q     <= ZERO;
         w2_q    <= ZERO;
         da1_q   <= 1'b0;
         da2_q   <= 1'b0;
         da3_q   <= 1'b0;
         da4_q   <= ZERO;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         w1_q    <= w1_d;
         g_q     <= g_d;
         w2_q    <= w2_d;
         da1_q   <= da1_d;
         da2_q   <= da2_d;
         da3_q   <= da3_d;
         da4_q   <= da4_d;
         busy_q  <= busy_d;
      end
   end

   assign bus.DA_test1 = da1_q;
   assign bus.DA_test2 = da2_q;
   assign bus.DA_test3 = da3_q;
   assign bus.DA_test4 = da4_q;
   assign bus.tg_busy  = busy_q;

endmodule

// File: tb/tb_tg_pulse_seq.sv
// Directed bench for tg_pulse_seq: cycle-exact pulse timing, zero-length
// segments, abort, frozen config, count wrap and asynchronous reset.
module tb_tg_pulse_seq;

   logic clk      = 1'b0;
   logic C_purstb = 1'b0;
   int   checks   = 0;
   int   errors   = 0;

   tg_pulse_seq_if #(.CNT_W(4)) bus ();

   tg_pulse_seq #(.CNT_W(4)) dut (
      .clk      (clk),
      .C_purstb (C_purstb),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // {DA_test1, DA_test2, DA_test3, tg_busy}
   wire [3:0] outs = {bus.DA_test1, bus.DA_test2, bus.DA_test3, bus.tg_busy};

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] expected_outs(input int k, input int w1, input int g, input int w2);
      int len;
      len = w1 + g + w2;
      return {(k >= 1 && k <= w1),
              (k > w1 + g && k <= len),
              (k == len + 1),
              (k >= 1 && k <= len + 1)};
   endfunction

   // One start pulse, then every cycle compared against the ideal burst shape.
   task automatic apply_stimulus(input int w1, input int g, input int w2,
                                 input string tag, input logic [3:0] count_after);
      int len;
      len = w1 + g + w2;
      bus.B_test1  = w1[3:0];
      bus.B_test2  = g[3:0];
      bus.B_test3  = w2[3:0];
      bus.tg_start = 1'b1;
      tick();
      bus.tg_start = 1'b0;
      check_output($sformatf("%s_k0", tag), outs, 4'b0000);
      for (int k = 1; k <= len + 2; k++) begin
         tick();
         check_output($sformatf("%s_k%0d", tag, k), outs, expected_outs(k, w1, g, w2));
         if (k == len + 1)
            check_output($sformatf("%s_count", tag), bus.DA_test4, count_after);
      end
   endtask

   initial begin
      int strobes;
      int cyc;

      bus.tg_start = 1'b0;
      bus.tg_abort = 1'b0;
      bus.B_test1  = '0;
      bus.B_test2  = '0;
      bus.B_test3  = '0;

      #12;
      check_output("reset_outs", outs, 4'b0000);
      check_output("reset_count", bus.DA_test4, 4'd0);
      @(negedge clk);
      C_purstb = 1'b1;
      tick();

      apply_stimulus(3, 2, 4, "b324", 4'd1);
      apply_stimulus(1, 0, 1, "gap0", 4'd2);
      apply_stimulus(0, 0, 5, "w2only", 4'd3);
      apply_stimulus(0, 0, 0, "allzero", 4'd4);

      // Abort in the middle of pulse 1.
      bus.B_test1  = 4'd4;
      bus.B_test2  = 4'd1;
      bus.B_test3  = 4'd1;
      bus.tg_start = 1'b1;
      tick();
      bus.tg_start = 1'b0;
      tick();
      tick();
      check_output("abort_pre", bus.DA_test1, 1'b1);
      bus.tg_abort = 1'b1;
      tick();
      bus.tg_abort = 1'b0;
      check_output("abort_outs", outs, 4'b0000);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check_output($sformatf("abort_quiet_k%0d", k), outs, 4'b0000);
      end
      check_output("abort_count", bus.DA_test4, 4'd4);

      // Start and abort together in IDLE: nothing starts.
      bus.tg_start = 1'b1;
      bus.tg_abort = 1'b1;
      tick();
      bus.tg_start = 1'b0;
      bus.tg_abort = 1'b0;
      tick();
      check_output("start_abort_k1", outs, 4'b0000);
      tick();
      check_output("start_abort_k2", outs, 4'b0000);

      // Config change and a second start mid-burst have no effect.
      bus.B_test1  = 4'd3;
      bus.B_test2  = 4'd2;
      bus.B_test3  = 4'd4;
      bus.tg_start = 1'b1;
      tick();
      bus.tg_start = 1'b0;
      for (int k = 1; k <= 14; k++) begin
         tick();
         check_output($sformatf("frozen_k%0d", k), outs, expected_outs(k, 3, 2, 4));
         if (k == 10)
            check_output("frozen_count", bus.DA_test4, 4'd5);
         if (k == 2) begin
            bus.B_test1  = 4'd1;
            bus.tg_start = 1'b1;
         end
         if (k == 3)
            bus.tg_start = 1'b0;
      end

      // Clear the count, then run 17 back-to-back bursts to see it wrap.
      C_purstb = 1'b0;
      #1;
      check_output("prewrap_count", bus.DA_test4, 4'd0);
      @(negedge clk);
      C_purstb = 1'b1;
      tick();

      bus.B_test1  = 4'd1;
      bus.B_test2  = 4'd0;
      bus.B_test3  = 4'd1;
      bus.tg_start = 1'b1;
      strobes = 0;
      cyc     = 0;
      while (strobes < 17 && cyc < 200) begin
         tick();
         cyc++;
         if (bus.DA_test3 === 1'b1) begin
            strobes++;
            check_output($sformatf("wrap_count_%0d", strobes), bus.DA_test4, strobes % 16);
         end
      end
      check_output("wrap_strobes", strobes, 17);
      check_output("wrap_final", bus.DA_test4, 4'd1);

      // Next burst begins; reset it mid-pulse without a clock edge.
      tick();
      tick();
      check_output("pre_async_da1", bus.DA_test1, 1'b1);
      #2;
      C_purstb = 1'b0;
      #1;
      check_output("async_outs", outs, 4'b0000);
      check_output("async_count", bus.DA_test4, 4'd0);
      bus.tg_start = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tg_pulse_seq.md
# tg_pulse_seq

Programmable two-pulse sequencer for the TG block. On a start request it latches the width/gap configuration (`B_test1..3`) and drives `DA_test1` then `DA_test2` as clean, cycle-exact pulses. It then emits a one-cycle done strobe on `DA_test3` and a wrapping burst count on `DA_test4`. The pulse-width checks in the TG assertion environment verify it directly: `DA_test1` must fall exactly `B_test1` cycles after it rises.

## Interface
Parameters:
- `CNT_W`, 4, width of config fields, internal counter and burst count.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `C_purstb`  in  1  asynchronous active-low reset.
- `tg_start`  in  1  burst request; sampled only in IDLE.
- `tg_abort`  in  1  synchronous abort; overrides everything except reset.
- `B_test1`  in  CNT_W  `DA_test1` high width, in cycles.
- `B_test2`  in  CNT_W  gap, in cycles, from `DA_test1` fall to `DA_test2` rise.
- `B_test3`  in  CNT_W  `DA_test2` high width, in cycles.
- `DA_test1`  out  1  pulse 1, registered.
- `DA_test2`  out  1  pulse 2, registered.
- `DA_test3`  out  1  done strobe, one cycle, registered.
- `DA_test4`  out  CNT_W  completed-burst count, wraps modulo 2^CNT_W.
- `tg_busy`  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, P1, GAP, P2, DONE. All outputs come from flops; no combinational paths from inputs to outputs.
- IDLE, `tg_start`=1: latch `B_test1..3` into `w1`/`g`/`w2`.
  - Load down-counter `cnt` with the first non-zero segment minus 1.
  - Enter that segment: P1 if `w1`≠0; else GAP if `g`≠0; else P2 if `w2`≠0; else DONE.
- P1: `DA_test1`=1.
  - `cnt`≠0: decrement.
  - `cnt`=0: go to the next non-zero segment (GAP, then P2, then DONE).
- GAP: both pulses low. Counts the same way; the next segment is P2 if `w2`≠0, else DONE.
- P2: `DA_test2`=1. Counts the same way; the next state is DONE.
- DONE: `DA_test3`=1 for exactly one cycle, `DA_test4` += 1 (wraps), then IDLE.
- Zero-valued fields skip their segment entirely. The all-zero config produces a bare done strobe.
- The latched config is frozen for the whole burst; changes to `B_test*` mid-burst have no effect.
- `tg_start` outside IDLE is ignored. Requests are not queued.
- `tg_abort`=1 in any state:
  - next state is IDLE and all pulses go low;
  - no done strobe;
  - `DA_test4` is unchanged.
- Simultaneous `tg_start` and `tg_abort` in IDLE: abort wins and the burst does not start.
- `tg_start` held high continuously: back-to-back bursts with exactly one IDLE cycle between DONE and the next segment.

## Timing
- Reset (`C_purstb`=0, asynchronous): state=IDLE, `cnt`=0, `w1`/`g`/`w2`=0, `DA_test1`=`DA_test2`=`DA_test3`=0, `DA_test4`=0, `tg_busy`=0.
- Release of reset is synchronous to `clk`. Reset asserted mid-burst clears all outputs immediately, without waiting for a clock edge.
- `tg_start` sampled at edge t:
  - `DA_test1` rises at t+1 and falls at t+1+`w1`, giving exactly `w1` cycles high.
  - `DA_test2` rises at t+1+`w1`+`g` and is high for `w2` cycles.
  - `DA_test3` is high in the single cycle after the last active segment.
  - `DA_test4` updates on the same edge that `DA_test3` rises.
- `g`=0: `DA_test2` rises on the same edge that `DA_test1` falls; the two are never both high.
- Total burst latency from the start edge to the `DA_test3` rise: 1+`w1`+`g`+`w2` cycles.
- `tg_busy` rises at t+1 and falls on the edge after the DONE cycle.

## Test plan
- Reset, then `B_test1`=3, `B_test2`=2, `B_test3`=4, one start pulse:
  - `DA_test1` high 3 cycles, low 2 cycles, `DA_test2` high 4 cycles;
  - `DA_test3` pulses once at start+10;
  - `DA_test4`=1;
  - the `DA_test1` width assertion passes.
- `B_test2`=0 (`B_test1`=1, `B_test3`=1): `DA_test2` rises on the edge `DA_test1` falls; `DA_test1`&`DA_test2` never 1.
- `B_test1`=0, `B_test2`=0, `B_test3`=5: no `DA_test1` activity; `DA_test2` rises at start+1 for 5 cycles. All-zero config: only `DA_test3` at start+1.
- Mid-P1 `tg_abort`: outputs low next cycle, no `DA_test3`, `DA_test4` unchanged, `tg_busy`=0.
- Mid-burst: change `B_test1` and re-pulse `tg_start`. The burst completes with the originally latched widths, and no second burst starts.
- `tg_start` held high for 17 bursts (`B_test1`=1, `B_test2`=0, `B_test3`=1): `DA_test4` wraps to 1. Assert `C_purstb` low mid-burst: all outputs 0 with no clock edge, `DA_test4`=0.
